// File: rtl/mod_sched_if.sv
// Bundle of the requester handshakes, the returned status and the shared
// subtractor connection used by mod_sched.
interface mod_sched_if #(
    parameter int WIDTH = 32
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             ack0;
    logic             ack1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             err;
    logic             busy;
    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic             dp_lt;
    logic [WIDTH-1:0] dp_diff;

    // Requesters plus the subtractor slice: drive requests and datapath results
    modport master (
        output req0, req1, a0, b0, a1, b1, dp_lt, dp_diff,
        input  ack0, ack1, done0, done1, result, err, busy, dp_a, dp_b
    );

    // Scheduler side
    modport slave (
        input  req0, req1, a0, b0, a1, b1, dp_lt, dp_diff,
        output ack0, ack1, done0, done1, result, err, busy, dp_a, dp_b
    );
endinterface

// File: rtl/mod_sched.sv
// Round-robin scheduler sharing one external modulo-subtract slice between
// two requesters. Grants a job, iterates rem -= div until rem < div (or the
// iteration cap), then returns a registered remainder with done/err status.
module mod_sched #(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 65535
) (
    input  logic       clk,
    input  logic       rst,     // asynchronous, active low
    mod_sched_if.slave sif
);
    localparam int ITER_W = (MAX_ITER < 2) ? 1 : $clog2(MAX_ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WIDTH-1:0]    r_rem;
    logic [WIDTH-1:0]    r_div;
    logic [ITER_W-1:0]   r_iter;
    logic                r_owner;
    logic                r_last_grant;
    logic [WIDTH-1:0]    r_result;
    logic                r_err;
    logic                r_ack0;
    logic                r_ack1;

    logic                w_any_req;
    logic                w_pick;
    logic [WIDTH-1:0]    w_a;
    logic [WIDTH-1:0]    w_b;
    logic                w_iter_max;

    // On a tie the requester that was not served last wins
    assign w_any_req  = sif.req0 | sif.req1;
    assign w_pick     = (sif.req0 & sif.req1) ? ~r_last_grant : sif.req1;
    assign w_a        = w_pick ? sif.a1 : sif.a0;
    assign w_b        = w_pick ? sif.b1 : sif.b0;
    assign w_iter_max = (r_iter == ITER_W'(MAX_ITER));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: zero divisor skips the subtract loop entirely
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next = (w_b == '0) ? S_DONE : S_SUB;
                end
            end
            S_SUB: begin
                if (sif.dp_lt || w_iter_max) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, subtract iteration, result/status and grant history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem        <= '0;
            r_div        <= '0;
            r_iter       <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_result     <= '0;
            r_err        <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_rem   <= w_a;
                        r_div   <= w_b;
                        r_iter  <= '0;
                        r_owner <= w_pick;
                        r_ack0  <= ~w_pick;
                        r_ack1  <= w_pick;
                        if (w_b == '0) begin
                            r_result <= w_a;
                            r_err    <= 1'b1;
                        end
                    end
                end
                S_SUB: begin
                    if (sif.dp_lt) begin
                        r_result <= r_rem;
                        r_err    <= 1'b0;
                    end else if (w_iter_max) begin
                        r_result <= r_rem;
                        r_err    <= 1'b1;
                    end else begin
                        r_rem  <= sif.dp_diff;
                        r_iter <= r_iter + ITER_W'(1);
                    end
                end
                S_DONE: begin
                    r_last_grant <= r_owner;
                end
                default: ;
            endcase
        end
    end

    assign sif.ack0   = r_ack0;
    assign sif.ack1   = r_ack1;
    assign sif.done0  = (r_state == S_DONE) && !r_owner;
    assign sif.done1  = (r_state == S_DONE) &&  r_owner;
    assign sif.busy   = (r_state != S_IDLE);
    assign sif.result = r_result;
    assign sif.err    = r_err;
    assign sif.dp_a   = r_rem;
    assign sif.dp_b   = r_div;
endmodule

// File: tb/tb_mod_sched.sv
// Self-checking bench for mod_sched: directed scenarios plus randomized jobs
// checked against a division-based reference model.
module tb_mod_sched;
    logic clk;
    logic rst;
    logic sel;                       // 0: default instance, 1: MAX_ITER=4 instance
    logic req0, req1;
    logic [31:0] a0, b0, a1, b1;

    int checks;
    int errors;

    mod_sched_if #(.WIDTH(32)) s1 ();
    mod_sched_if #(.WIDTH(32)) s4 ();

    mod_sched #(.WIDTH(32), .MAX_ITER(65535)) u_dut (.clk(clk), .rst(rst), .sif(s1));
    mod_sched #(.WIDTH(32), .MAX_ITER(4))     u_dut4 (.clk(clk), .rst(rst), .sif(s4));

    // Requests routed to the selected instance only
    assign s1.req0 = req0 & ~sel;
    assign s1.req1 = req1 & ~sel;
    assign s4.req0 = req0 & sel;
    assign s4.req1 = req1 & sel;
    assign s1.a0 = a0; assign s1.b0 = b0; assign s1.a1 = a1; assign s1.b1 = b1;
    assign s4.a0 = a0; assign s4.b0 = b0; assign s4.a1 = a1; assign s4.b1 = b1;

    // Shared subtractor slice models
    assign s1.dp_lt   = s1.dp_a < s1.dp_b;
    assign s1.dp_diff = s1.dp_a - s1.dp_b;
    assign s4.dp_lt   = s4.dp_a < s4.dp_b;
    assign s4.dp_diff = s4.dp_a - s4.dp_b;

    logic m_ack0, m_ack1, m_done0, m_done1, m_err, m_busy;
    logic [31:0] m_result;
    assign m_ack0   = sel ? s4.ack0   : s1.ack0;
    assign m_ack1   = sel ? s4.ack1   : s1.ack1;
    assign m_done0  = sel ? s4.done0  : s1.done0;
    assign m_done1  = sel ? s4.done1  : s1.done1;
    assign m_err    = sel ? s4.err    : s1.err;
    assign m_busy   = sel ? s4.busy   : s1.busy;
    assign m_result = sel ? s4.result : s1.result;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Issues one job; returns cycles from ack edge to done sample
    task automatic run_one(input bit who, input logic [31:0] a, input logic [31:0] b,
                           output bit got_ack, output int lat, output logic [31:0] res,
                           output logic e, output logic busy_ack, output logic busy_done);
        if (!who) begin req0 = 1'b1; a0 = a; b0 = b; end
        else      begin req1 = 1'b1; a1 = a; b1 = b; end
        got_ack = 1'b0;
        for (int n = 0; n < 20 && !got_ack; n++) begin
            tick;
            got_ack = who ? m_ack1 : m_ack0;
        end
        busy_ack = m_busy;
        req0 = 1'b0;
        req1 = 1'b0;
        lat = 0;
        if (got_ack) begin
            while (!(who ? m_done1 : m_done0) && lat < 100) begin
                tick;
                lat++;
            end
        end
        res = m_result;
        e = m_err;
        busy_done = m_busy;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b0; sel = 1'b0;
        req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        #1;
        checks++;
        if ({s1.ack0, s1.ack1, s1.done0, s1.done1, s1.err, s1.busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {s1.ack0, s1.ack1, s1.done0, s1.done1, s1.err, s1.busy});
        end
        checks++;
        if ({s1.result, s1.dp_a, s1.dp_b} !== 96'b0) begin
            errors++;
            $display("FAIL reset_data: result %0d dp_a %0d dp_b %0d expected 0",
                     s1.result, s1.dp_a, s1.dp_b);
        end
        do_reset;
    endtask

    task automatic test_single;
        bit g; int lat; logic [31:0] r; logic e, ba, bd;
        sel = 1'b0;
        run_one(1'b0, 32'd17, 32'd5, g, lat, r, e, ba, bd);
        checks++;
        if (g !== 1'b1) begin errors++; $display("FAIL single_ack: got %0b expected 1", g); end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL single_latency: got %0d expected 4", lat); end
        checks++;
        if ({r, e} !== {32'd2, 1'b0}) begin
            errors++; $display("FAIL single_result: got %0d err %0b expected 2 err 0", r, e);
        end
        checks++;
        if ({ba, bd, m_busy} !== 3'b110) begin
            errors++; $display("FAIL single_busy: got %b expected 110", {ba, bd, m_busy});
        end
    endtask

    task automatic test_q0;
        bit g; int lat; logic [31:0] r; logic e, ba, bd;
        sel = 1'b0;
        run_one(1'b1, 32'd3, 32'd7, g, lat, r, e, ba, bd);
        checks++;
        if (!g || lat !== 1) begin
            errors++; $display("FAIL q0_latency: ack %0b lat %0d expected ack 1 lat 1", g, lat);
        end
        checks++;
        if ({r, e} !== {32'd3, 1'b0}) begin
            errors++; $display("FAIL q0_result: got %0d err %0b expected 3 err 0", r, e);
        end
    endtask

    task automatic test_divzero;
        bit g; int lat; logic [31:0] r; logic e, ba, bd;
        sel = 1'b0;
        run_one(1'b0, 32'd9, 32'd0, g, lat, r, e, ba, bd);
        checks++;
        if (!g || lat !== 0) begin
            errors++; $display("FAIL divzero_same_cycle: ack %0b lat %0d expected ack 1 lat 0", g, lat);
        end
        checks++;
        if ({r, e} !== {32'd9, 1'b1}) begin
            errors++; $display("FAIL divzero_result: got %0d err %0b expected 9 err 1", r, e);
        end
    endtask

    task automatic test_max_iter;
        bit g; int lat; logic [31:0] r; logic e, ba, bd;
        sel = 1'b1;
        run_one(1'b0, 32'd100, 32'd10, g, lat, r, e, ba, bd);
        sel = 1'b0;
        checks++;
        if (!g || lat !== 5) begin
            errors++; $display("FAIL maxiter_latency: ack %0b lat %0d expected ack 1 lat 5", g, lat);
        end
        checks++;
        if ({r, e} !== {32'd60, 1'b1}) begin
            errors++; $display("FAIL maxiter_result: got %0d err %0b expected 60 err 1", r, e);
        end
    endtask

    task automatic test_back_to_back;
        int gq[$];
        logic [31:0] rq[$];
        int exp_who;
        logic [31:0] exp_res;
        do_reset;
        sel = 1'b0;
        req0 = 1'b1; a0 = 32'd10; b0 = 32'd3;
        req1 = 1'b1; a1 = 32'd20; b1 = 32'd6;
        for (int c = 0; c < 200 && rq.size() < 4; c++) begin
            tick;
            if (m_ack0) gq.push_back(0);
            if (m_ack1) gq.push_back(1);
            if (m_done0 || m_done1) rq.push_back(m_result);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) tick;
        checks++;
        if (gq.size() !== 4 || rq.size() !== 4) begin
            errors++;
            $display("FAIL b2b_count: grants %0d dones %0d expected 4 and 4", gq.size(), rq.size());
        end
        for (int i = 0; i < 4; i++) begin
            exp_who = i % 2;
            exp_res = (exp_who == 1) ? 32'd20 % 32'd6 : 32'd10 % 32'd3;
            if (i < gq.size()) begin
                checks++;
                if (gq[i] !== exp_who) begin
                    errors++; $display("FAIL b2b_grant%0d: got %0d expected %0d", i, gq[i], exp_who);
                end
            end
            if (i < rq.size()) begin
                checks++;
                if (rq[i] !== exp_res) begin
                    errors++; $display("FAIL b2b_result%0d: got %0d expected %0d", i, rq[i], exp_res);
                end
            end
        end
    endtask

    task automatic test_reset_mid_job;
        bit g;
        bit saw_done;
        sel = 1'b0;
        req0 = 1'b1; a0 = 32'd1000; b0 = 32'd1;
        g = 1'b0;
        for (int n = 0; n < 20 && !g; n++) begin
            tick;
            g = m_ack0;
        end
        req0 = 1'b0;
        checks++;
        if (!g) begin errors++; $display("FAIL midrst_ack: got 0 expected 1"); end
        repeat (5) tick;
        checks++;
        if (s1.busy !== 1'b1) begin errors++; $display("FAIL midrst_in_sub: busy %0b expected 1", s1.busy); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({s1.ack0, s1.ack1, s1.done0, s1.done1, s1.err, s1.busy} !== 6'b0 ||
            {s1.result, s1.dp_a, s1.dp_b} !== 96'b0) begin
            errors++;
            $display("FAIL midrst_outputs: ctrl %b result %0d dp_a %0d dp_b %0d expected all 0",
                     {s1.ack0, s1.ack1, s1.done0, s1.done1, s1.err, s1.busy},
                     s1.result, s1.dp_a, s1.dp_b);
        end
        saw_done = 1'b0;
        repeat (2) begin
            tick;
            if (s1.done0 || s1.done1) saw_done = 1'b1;
        end
        rst = 1'b1;
        repeat (4) begin
            tick;
            if (s1.done0 || s1.done1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got 1 expected 0"); end
        req0 = 1'b1; a0 = 32'd5; b0 = 32'd2;
        req1 = 1'b1; a1 = 32'd7; b1 = 32'd3;
        g = 1'b0;
        for (int n = 0; n < 20 && !g; n++) begin
            tick;
            g = s1.ack0 | s1.ack1;
        end
        checks++;
        if ({s1.ack0, s1.ack1} !== 2'b10) begin
            errors++; $display("FAIL midrst_tie_grant: got ack0/ack1 %b expected 10", {s1.ack0, s1.ack1});
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (8) tick;
    endtask

    task automatic test_random;
        bit g; int lat; logic [31:0] r; logic e, ba, bd;
        bit who;
        longint a, b, q, mx, exp_res, exp_lat;
        logic exp_err;
        for (int j = 0; j < 40; j++) begin
            sel = 1'($urandom % 2);
            who = 1'($urandom % 2);
            b = longint'($urandom_range(0, 15));
            q = longint'($urandom_range(0, 8));
            a = (b == 0) ? longint'($urandom_range(0, 1000)) : q * b + longint'($urandom_range(0, 32'(b - 1)));
            mx = sel ? 4 : 65535;
            if (b == 0) begin
                exp_res = a; exp_err = 1'b1; exp_lat = 0;
            end else if (a / b > mx) begin
                exp_res = a - mx * b; exp_err = 1'b1; exp_lat = mx + 1;
            end else begin
                exp_res = a % b; exp_err = 1'b0; exp_lat = a / b + 1;
            end
            run_one(who, 32'(a), 32'(b), g, lat, r, e, ba, bd);
            checks++;
            if (!g || longint'(lat) !== exp_lat || {r, e} !== {32'(exp_res), exp_err}) begin
                errors++;
                $display("FAIL random%0d: sel %0b who %0b a %0d b %0d got ack %0b lat %0d res %0d err %0b expected lat %0d res %0d err %0b",
                         j, sel, who, a, b, g, lat, r, e, exp_lat, exp_res, exp_err);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_single;
        test_q0;
        test_divzero;
        test_max_iter;
        test_back_to_back;
        test_random;
        test_reset_mid_job;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
